// File: rtl/dct_butterfly8.sv
// First butterfly stage of the 8-point DCT row path: ping-pong row buffer feeding
// mirrored-pair sums (s0..s3) then differences (d0..d3), one result per cycle.
module dct_butterfly8 #(
   parameter int DW  = 8,
   parameter int NPT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW:0]   out_data,
   output logic [2:0]    out_idx,
   output logic          out_last
);

   // Carry-lookahead by recursive doubling; bit 0 of the prefix carries cin.
   function automatic logic [8:0] recurse8(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin);
      logic [8:0] g, p, gn, pn;
      g = {a & b, cin};
      p = {a ^ b, 1'b0};
      for (int d = 1; d < 9; d = d * 2) begin
         gn = g;
         pn = p;
         for (int i = d; i < 9; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      return {g[8], (a ^ b) ^ g[7:0]};
   endfunction

   logic [1:0][NPT-1:0][DW-1:0] mem_q;
   logic [1:0]  full_q;
   logic        wr_bank_q, rd_bank_q;
   logic [2:0]  wr_cnt_q, rd_cnt_q;
   logic        out_valid_q, out_last_q;
   logic [DW:0] out_data_q;
   logic [2:0]  out_idx_q;

   logic          wr_fire, rd_load, is_diff, rd_last;
   logic [DW-1:0] op_a, op_b;
   logic [8:0]    add_r;
   logic [DW:0]   res;

   assign in_ready = ~full_q[wr_bank_q];
   assign wr_fire  = in_valid & in_ready & ~clr;
   assign rd_load  = full_q[rd_bank_q] & (~out_valid_q | out_ready) & ~clr;
   assign rd_last  = (rd_cnt_q == 3'(NPT - 1));

   // Differences reuse the adder as a + ~b + 1; the 9th bit is the inverted carry.
   assign is_diff = rd_cnt_q[2];
   assign op_a    = mem_q[rd_bank_q][{1'b0, rd_cnt_q[1:0]}];
   assign op_b    = mem_q[rd_bank_q][{1'b1, ~rd_cnt_q[1:0]}];
   assign add_r   = recurse8(op_a, is_diff ? ~op_b : op_b, is_diff);
   assign res     = {add_r[8] ^ is_diff, add_r[7:0]};

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_bank_q][wr_cnt_q] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else if (clr) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'(NPT - 1)) begin
               full_q[wr_bank_q] <= 1'b1;
               wr_bank_q         <= ~wr_bank_q;
            end
         end
         // Write and read banks never coincide while full, so these bits never collide.
         if (rd_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res;
            out_idx_q   <= rd_cnt_q;
            out_last_q  <= rd_last;
            rd_cnt_q    <= rd_cnt_q + 3'd1;
            if (rd_last) begin
               full_q[rd_bank_q] <= 1'b0;
               rd_bank_q         <= ~rd_bank_q;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_butterfly8.sv
// Directed bench for dct_butterfly8: hand-computed rows, ping-pong, random stalls,
// reset and clear mid-flight; a negedge monitor scores every accepted result.
module tb_dct_butterfly8;

   logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid, out_last;
   logic [8:0] out_data;
   logic [2:0] out_idx;

   int n_chk = 0, n_fail = 0;
   logic [11:0] exp_q[$];
   logic [11:0] col_e;
   logic        pv = 1'b0, pr = 1'b0, pclr = 1'b0, prst = 1'b0, pl = 1'b0;
   logic [8:0]  pd = '0;
   logic [2:0]  pi = '0;
   logic        rnd_on = 1'b0;

   logic [7:0][7:0] drow[4];
   logic [7:0][8:0] dexp[4];
   logic [7:0][7:0] rr, p0, p1, p2;

   dct_butterfly8 dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard plus stall-stability monitor.
   always @(negedge clk) begin
      if (pv && !pr && !pclr && prst && rst_n) begin
         check("stall_data", out_data, pd);
         check("stall_idx", out_idx, pi);
         check("stall_last", out_last, pl);
      end
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("spurious", out_valid, 0);
         else begin
            col_e = exp_q.pop_front();
            check("data", out_data, col_e[8:0]);
            check("idx", out_idx, col_e[11:9]);
            check("last", out_last, col_e[11:9] == 3'd7);
         end
      end
      pv = out_valid; pr = out_ready; pclr = clr; prst = rst_n;
      pd = out_data; pi = out_idx; pl = out_last;
   end

   function automatic logic [7:0][8:0] ref_row(input logic [7:0][7:0] x);
      logic [7:0][8:0] r;
      int s, d;
      for (int k = 0; k < 4; k++) begin
         s = int'(x[k]) + int'(x[7-k]);
         d = int'(x[k]) - int'(x[7-k]);
         r[k]   = s[8:0];
         r[k+4] = d[8:0];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0][8:0] ex, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({3'(i), ex[i]});
   endtask

   task automatic send_row(input logic [7:0][7:0] row, input int n);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         in_valid = 1'b1;
         in_data  = row[i];
         @(negedge clk);
         while (!in_ready && t < 1000) begin
            t++;
            @(negedge clk);
         end
         if (t >= 1000) check("in_timeout", t, 0);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int maxc);
      int t = 0;
      while (exp_q.size() != 0 && t < maxc) begin
         tick();
         t++;
      end
      check("drain", exp_q.size(), 0);
      tick();
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      drow[0] = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      dexp[0] = {9'h1F6, 9'h1E2, 9'h1CE, 9'h1BA, 9'h05A, 9'h05A, 9'h05A, 9'h05A};
      drow[1] = {8{8'd255}};
      dexp[1] = {9'h000, 9'h000, 9'h000, 9'h000, 9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE};
      drow[2] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
      dexp[2] = {9'h000, 9'h000, 9'h000, 9'h0FF, 9'h000, 9'h000, 9'h000, 9'h0FF};
      drow[3] = {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      dexp[3] = {9'h000, 9'h000, 9'h000, 9'h101, 9'h000, 9'h000, 9'h000, 9'h0FF};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      rst_n = 1'b1;
      tick();

      // Basic row and latency
      out_ready = 1'b1;
      push_exp(dexp[0], 8);
      send_row(drow[0], 8);
      @(negedge clk);
      check("lat_pre", out_valid, 0);
      @(negedge clk);
      check("lat_s0_valid", out_valid, 1);
      check("lat_s0_idx", out_idx, 0);
      drain(50);

      // Extremes
      for (int r = 1; r < 4; r++) begin
         push_exp(dexp[r], 8);
         send_row(drow[r], 8);
         drain(50);
      end

      // Ping-pong under backpressure
      for (int j = 0; j < 8; j++) begin
         p0[j] = 8'($urandom_range(0, 255));
         p1[j] = 8'($urandom_range(0, 255));
         p2[j] = 8'($urandom_range(0, 255));
      end
      out_ready = 1'b0;
      push_exp(ref_row(p0), 8);
      push_exp(ref_row(p1), 8);
      send_row(p0, 8);
      send_row(p1, 8);
      in_valid = 1'b1;
      in_data  = p2[0];
      repeat (3) begin
         @(negedge clk);
         check("pp_full", in_ready, 0);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      t = 0;
      while (!(out_valid && out_idx == 3'd6) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("pp_rdy_before_d3", in_ready, 0);
      @(negedge clk);
      check("pp_d3_idx", out_idx, 7);
      check("pp_rdy_after_d3", in_ready, 1);
      push_exp(ref_row(p2), 8);
      tick();
      send_row(p2, 8);
      drain(100);

      // Random rows with random out_ready
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk);
            #1;
            if (rnd_on) out_ready = 1'($urandom_range(0, 1));
         end
      join_none
      for (int r = 0; r < 100; r++) begin
         for (int j = 0; j < 8; j++) rr[j] = 8'($urandom_range(0, 255));
         push_exp(ref_row(rr), 8);
         send_row(rr, 8);
      end
      drain(5000);
      rnd_on = 1'b0;
      tick();
      tick();
      out_ready = 1'b1;

      // Reset mid-row discards the partial row
      send_row(drow[1], 5);
      rst_n = 1'b0;
      tick();
      check("mrst_in_ready", in_ready, 1);
      check("mrst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      tick();
      push_exp(dexp[0], 8);
      send_row(drow[0], 8);
      drain(50);

      // Clear during a drain after idx 2
      out_ready = 1'b0;
      push_exp(dexp[0], 3);
      send_row(drow[0], 8);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      check("clr_out_valid", out_valid, 0);
      check("clr_in_ready", in_ready, 1);
      check("clr_out_data", out_data, 0);
      check("clr_exp_left", exp_q.size(), 0);
      tick();
      out_ready = 1'b1;
      push_exp(dexp[3], 8);
      send_row(drow[3], 8);
      drain(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
